// File: rtl/peripheral_dbg_jsp_apb_mc_if.sv
// APB register-window bus for the multi-channel JSP buffer.
// Signal names keep the original jsp_* APB naming.
interface peripheral_dbg_jsp_apb_mc_if;
    logic       jsp_PSEL;
    logic       jsp_PENABLE;
    logic       jsp_PWRITE;
    logic [2:0] jsp_PADDR;
    logic [7:0] jsp_PWDATA;
    logic [7:0] jsp_PRDATA;
    logic       jsp_PREADY;
    logic       jsp_PSLVERR;

    modport master (
        output jsp_PSEL, jsp_PENABLE, jsp_PWRITE, jsp_PADDR, jsp_PWDATA,
        input  jsp_PRDATA, jsp_PREADY, jsp_PSLVERR
    );

    modport slave (
        input  jsp_PSEL, jsp_PENABLE, jsp_PWRITE, jsp_PADDR, jsp_PWDATA,
        output jsp_PRDATA, jsp_PREADY, jsp_PSLVERR
    );
endinterface

// File: rtl/peripheral_dbg_jsp_apb_mc.sv
// Multi-channel JTAG serial port buffer: per-channel RX/TX FIFOs behind an APB window.
// Optional macro PERIPHERAL_DBG_JSP_LOOPBACK_EN adds a per-channel TX->RX loopback (IER bit7).
module peripheral_dbg_jsp_apb_mc #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    peripheral_dbg_jsp_apb_mc_if.slave     apb,
    output logic                           int_o,
    output logic [CHANNELS-1:0]            dbg_tx_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] dbg_tx_data,
    input  logic [CHANNELS-1:0]            dbg_tx_ready,
    input  logic [CHANNELS-1:0]            dbg_rx_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] dbg_rx_data,
    output logic [CHANNELS-1:0]            dbg_rx_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_STATUS = 3'd1,
        REG_CHSEL  = 3'd2,
        REG_IER    = 3'd3,
        REG_RXCNT  = 3'd4,
        REG_TXCNT  = 3'd5,
        REG_RSV6   = 3'd6,
        REG_RSV7   = 3'd7
    } reg_addr_t;

    reg_addr_t w_addr;
    logic      w_access, w_wr, w_rd;
    logic      w_wr_data, w_rd_data, w_wr_status, w_wr_chsel, w_wr_ier;
    logic      w_chsel_ok;
    logic [CW-1:0] r_chsel;
    logic          r_int;

    logic [CHANNELS-1:0]                 w_sel;
    logic [CHANNELS-1:0]                 w_irq;
    logic [CHANNELS-1:0]                 w_tx_full_all, w_rx_empty_all, w_txerr_all;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] w_rx_head_all;
    logic [CHANNELS-1:0][PW-1:0]         w_rx_cnt_all, w_tx_cnt_all;
    logic [CHANNELS-1:0][7:0]            w_ier_all;

    logic                  w_s_tx_full, w_s_rx_empty, w_s_txerr;
    logic [DATA_WIDTH-1:0] w_s_rx_head;
    logic [PW-1:0]         w_s_rx_cnt, w_s_tx_cnt;
    logic [7:0]            w_s_ier;

    assign w_addr      = reg_addr_t'(apb.jsp_PADDR);
    assign w_access    = apb.jsp_PSEL & apb.jsp_PENABLE;
    assign w_wr        = w_access & apb.jsp_PWRITE;
    assign w_rd        = w_access & ~apb.jsp_PWRITE;
    assign w_wr_data   = w_wr && (w_addr == REG_DATA);
    assign w_rd_data   = w_rd && (w_addr == REG_DATA);
    assign w_wr_status = w_wr && (w_addr == REG_STATUS);
    assign w_wr_chsel  = w_wr && (w_addr == REG_CHSEL);
    assign w_wr_ier    = w_wr && (w_addr == REG_IER);
    assign w_chsel_ok  = (32'(apb.jsp_PWDATA) < 32'(CHANNELS));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_chsel <= '0;
            r_int   <= 1'b0;
        end else begin
            if (w_wr_chsel && w_chsel_ok) r_chsel <= apb.jsp_PWDATA[CW-1:0];
            r_int <= |w_irq;
        end
    end

    assign int_o = r_int;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
        logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
        logic [PW-1:0]         r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
        logic [PW-1:0]         w_tx_cnt, w_rx_cnt;
        logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
        logic                  w_loop, w_loop_mv;
        logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
        logic [DATA_WIDTH-1:0] w_tx_head, w_rx_din;
        logic [1:0]            r_ier;
        logic                  r_txerr;

        assign w_sel[c]   = (r_chsel == CW'(c));
        assign w_tx_cnt   = r_tx_wr - r_tx_rd;
        assign w_rx_cnt   = r_rx_wr - r_rx_rd;
        assign w_tx_full  = (w_tx_cnt == PW'(FIFO_DEPTH));
        assign w_rx_full  = (w_rx_cnt == PW'(FIFO_DEPTH));
        assign w_tx_empty = (r_tx_wr == r_tx_rd);
        assign w_rx_empty = (r_rx_wr == r_rx_rd);
        assign w_tx_head  = r_tx_mem[r_tx_rd[AW-1:0]];

`ifdef PERIPHERAL_DBG_JSP_LOOPBACK_EN
        logic r_loop;
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_ier  <= '0;
                r_loop <= 1'b0;
            end else if (w_wr_ier && w_sel[c]) begin
                r_ier  <= apb.jsp_PWDATA[1:0];
                r_loop <= apb.jsp_PWDATA[7];
            end
        end
        assign w_loop = r_loop;
`else
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn)                  r_ier <= '0;
            else if (w_wr_ier && w_sel[c]) r_ier <= apb.jsp_PWDATA[1:0];
        end
        assign w_loop = 1'b0;
`endif

        // Loopback owns both FIFOs of the channel, so the debug streams are masked off.
        assign w_loop_mv = w_loop & ~w_tx_empty & ~w_rx_full;
        assign w_tx_push = w_wr_data & w_sel[c] & ~w_tx_full;
        assign w_tx_pop  = (~w_loop & ~w_tx_empty & dbg_tx_ready[c]) | w_loop_mv;
        assign w_rx_push = (~w_loop & ~w_rx_full & dbg_rx_valid[c]) | w_loop_mv;
        assign w_rx_pop  = w_rd_data & w_sel[c] & ~w_rx_empty;
        assign w_rx_din  = w_loop ? w_tx_head : dbg_rx_data[c*DATA_WIDTH +: DATA_WIDTH];

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_tx_wr <= '0;
                r_tx_rd <= '0;
                r_rx_wr <= '0;
                r_rx_rd <= '0;
                r_txerr <= 1'b0;
            end else begin
                if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
                if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
                if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
                if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
                if (w_wr_data && w_sel[c] && w_tx_full)
                    r_txerr <= 1'b1;
                else if (w_wr_status && w_sel[c] && apb.jsp_PWDATA[2])
                    r_txerr <= 1'b0;
            end
        end

        always_ff @(posedge PCLK) begin
            if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= apb.jsp_PWDATA;
            if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= w_rx_din;
        end

        assign dbg_tx_valid[c] = ~w_tx_empty & ~w_loop;
        assign dbg_rx_ready[c] = ~w_rx_full & ~w_loop;
        assign dbg_tx_data[c*DATA_WIDTH +: DATA_WIDTH] = w_tx_head;

        assign w_irq[c]          = (r_ier[0] & ~w_rx_empty) | (r_ier[1] & w_tx_empty);
        assign w_tx_full_all[c]  = w_tx_full;
        assign w_rx_empty_all[c] = w_rx_empty;
        assign w_txerr_all[c]    = r_txerr;
        assign w_rx_head_all[c]  = r_rx_mem[r_rx_rd[AW-1:0]];
        assign w_rx_cnt_all[c]   = w_rx_cnt;
        assign w_tx_cnt_all[c]   = w_tx_cnt;
        assign w_ier_all[c]      = {w_loop, 5'b0, r_ier};
    end

    always_comb begin
        w_s_tx_full  = 1'b0;
        w_s_rx_empty = 1'b0;
        w_s_txerr    = 1'b0;
        w_s_rx_head  = '0;
        w_s_rx_cnt   = '0;
        w_s_tx_cnt   = '0;
        w_s_ier      = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (w_sel[c]) begin
                w_s_tx_full  = w_tx_full_all[c];
                w_s_rx_empty = w_rx_empty_all[c];
                w_s_txerr    = w_txerr_all[c];
                w_s_rx_head  = w_rx_head_all[c];
                w_s_rx_cnt   = w_rx_cnt_all[c];
                w_s_tx_cnt   = w_tx_cnt_all[c];
                w_s_ier      = w_ier_all[c];
            end
        end
    end

    assign apb.jsp_PREADY = 1'b1;

    always_comb begin
        apb.jsp_PRDATA  = '0;
        apb.jsp_PSLVERR = 1'b0;
        if (w_access) begin
            case (w_addr)
                REG_DATA: begin
                    if (apb.jsp_PWRITE) begin
                        apb.jsp_PSLVERR = w_s_tx_full;
                    end else begin
                        apb.jsp_PSLVERR = w_s_rx_empty;
                        apb.jsp_PRDATA  = w_s_rx_empty ? '0 : w_s_rx_head;
                    end
                end
                REG_STATUS: if (!apb.jsp_PWRITE)
                    apb.jsp_PRDATA = {5'b0, w_s_txerr, ~w_s_tx_full, ~w_s_rx_empty};
                REG_CHSEL: begin
                    if (apb.jsp_PWRITE) apb.jsp_PSLVERR = ~w_chsel_ok;
                    else                apb.jsp_PRDATA  = 8'(r_chsel);
                end
                REG_IER:   if (!apb.jsp_PWRITE) apb.jsp_PRDATA = w_s_ier;
                REG_RXCNT: if (!apb.jsp_PWRITE) apb.jsp_PRDATA = 8'(w_s_rx_cnt);
                REG_TXCNT: if (!apb.jsp_PWRITE) apb.jsp_PRDATA = 8'(PW'(FIFO_DEPTH) - w_s_tx_cnt);
                default:   apb.jsp_PSLVERR = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_peripheral_dbg_jsp_apb_mc.sv
// Scoreboard bench for peripheral_dbg_jsp_apb_mc (default parameters: 4 channels, depth 16).
module tb_peripheral_dbg_jsp_apb_mc;
    localparam int CH = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          int_o;
    logic [CH-1:0]   dbg_tx_valid, dbg_tx_ready, dbg_rx_valid, dbg_rx_ready;
    logic [CH*8-1:0] dbg_tx_data, dbg_rx_data;

    peripheral_dbg_jsp_apb_mc_if bus();

    peripheral_dbg_jsp_apb_mc #(.CHANNELS(CH), .DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus), .int_o(int_o),
        .dbg_tx_valid(dbg_tx_valid), .dbg_tx_data(dbg_tx_data), .dbg_tx_ready(dbg_tx_ready),
        .dbg_rx_valid(dbg_rx_valid), .dbg_rx_data(dbg_rx_data), .dbg_rx_ready(dbg_rx_ready)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { int ch; logic [7:0] d; } tx_exp_t;
    tx_exp_t    q_tx[$];
    logic [7:0] q_rd[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output logic err);
        @(negedge PCLK);
        bus.jsp_PSEL = 1'b1; bus.jsp_PENABLE = 1'b0; bus.jsp_PWRITE = wr;
        bus.jsp_PADDR = a;   bus.jsp_PWDATA = wd;
        @(negedge PCLK);
        bus.jsp_PENABLE = 1'b1;
        #1;
        rd  = bus.jsp_PRDATA;
        err = bus.jsp_PSLVERR;
        @(negedge PCLK);
        bus.jsp_PSEL = 1'b0; bus.jsp_PENABLE = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d, output logic err);
        logic [7:0] rd;
        apb_xfer(1'b1, a, d, rd, err);
    endtask

    task automatic expect_rd(input string tag, input logic [2:0] a, input logic [7:0] d, input logic e);
        logic [7:0] rd;
        logic err;
        apb_xfer(1'b0, a, 8'h00, rd, err);
        check(tag, rd, d);
        check({tag, "_err"}, err, e);
    endtask

    // Push a char to TX of the currently selected channel and record it for the monitor.
    task automatic tx_write(input string tag, input int ch, input logic [7:0] d, input logic exp_err);
        logic err;
        wr_reg(3'd0, d, err);
        check(tag, err, exp_err);
        if (!exp_err) q_tx.push_back('{ch, d});
    endtask

    task automatic rx_send(input int ch, input logic [7:0] d);
        int n = 0;
        @(negedge PCLK);
        dbg_rx_valid[ch] = 1'b1;
        dbg_rx_data[ch*8 +: 8] = d;
        #1;
        while (!dbg_rx_ready[ch] && n < 50) begin
            @(negedge PCLK); #1; n++;
        end
        if (!dbg_rx_ready[ch]) check("rx_timeout", 32'd0, 32'd1);
        else q_rd.push_back(d);
        @(posedge PCLK); #1;
        dbg_rx_valid[ch] = 1'b0;
    endtask

    task automatic rx_read(input string tag);
        logic [7:0] rd, exp;
        logic err;
        if (q_rd.size() == 0) begin
            check({tag, "_noexp"}, 32'd0, 32'd1);
        end else begin
            exp = q_rd.pop_front();
            apb_xfer(1'b0, 3'd0, 8'h00, rd, err);
            check(tag, rd, exp);
            check({tag, "_err"}, err, 1'b0);
        end
    endtask

    // Debug-side TX monitor: every accepted char must match the oldest expected one of its channel.
    always begin : tx_mon
        int idx;
        @(negedge PCLK);
        #2;
        for (int c = 0; c < CH; c++) begin
            if (dbg_tx_valid[c] && dbg_tx_ready[c]) begin
                idx = -1;
                foreach (q_tx[i]) if (idx < 0 && q_tx[i].ch == c) idx = i;
                if (idx < 0) begin
                    check("tx_unexpected", 32'(c), 32'hFFFF);
                end else begin
                    check("tx_char", dbg_tx_data[c*8 +: 8], q_tx[idx].d);
                    q_tx.delete(idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic err;
        bus.jsp_PSEL = 1'b0; bus.jsp_PENABLE = 1'b0; bus.jsp_PWRITE = 1'b0;
        bus.jsp_PADDR = '0;  bus.jsp_PWDATA = '0;
        dbg_tx_ready = '0; dbg_rx_valid = '0; dbg_rx_data = '0;

        // Reset state
        #12;
        check("rst_int", int_o, 1'b0);
        check("rst_txv", dbg_tx_valid, 4'h0);
        check("rst_rxr", dbg_rx_ready, 4'hF);
        check("rst_prdata", bus.jsp_PRDATA, 8'h00);
        check("rst_slverr", bus.jsp_PSLVERR, 1'b0);
        @(negedge PCLK); PRESETn = 1'b1;
        expect_rd("st0", 3'd1, 8'h02, 1'b0);
        expect_rd("rxcnt0", 3'd4, 8'd0, 1'b0);
        expect_rd("txcnt0", 3'd5, 8'd16, 1'b0);
        check("int0", int_o, 1'b0);
        check("pready", bus.jsp_PREADY, 1'b1);
        expect_rd("rsv6", 3'd6, 8'h00, 1'b1);
        wr_reg(3'd7, 8'h55, err); check("rsv7_wr", err, 1'b1);
        wr_reg(3'd4, 8'h55, err); check("ro_wr", err, 1'b0);
        expect_rd("rxcnt_ro", 3'd4, 8'd0, 1'b0);

        // Channel 2 TX
        wr_reg(3'd2, 8'd2, err); check("chsel2", err, 1'b0);
        tx_write("tx2a", 2, 8'h41, 1'b0);
        check("txv_ch2", dbg_tx_valid, 4'b0100);
        check("txd_ch2", dbg_tx_data[23:16], 8'h41);
        tx_write("tx2b", 2, 8'h42, 1'b0);
        expect_rd("txcnt2", 3'd5, 8'd14, 1'b0);
        @(negedge PCLK); dbg_tx_ready[2] = 1'b1;
        repeat (2) @(negedge PCLK);
        dbg_tx_ready[2] = 1'b0;
        #1;
        check("txv_drained", dbg_tx_valid, 4'h0);
        expect_rd("txcnt2_back", 3'd5, 8'd16, 1'b0);

        // Channel 1 TX overflow and sticky TXERR
        wr_reg(3'd2, 8'd1, err);
        for (int unsigned i = 0; i < 16; i++) tx_write("tx1_fill", 1, 8'(8'h10 + i), 1'b0);
        tx_write("tx1_ovf", 1, 8'hEE, 1'b1);
        expect_rd("st_txerr", 3'd1, 8'h04, 1'b0);
        expect_rd("txcnt_full", 3'd5, 8'd0, 1'b0);
        wr_reg(3'd1, 8'h04, err); check("st_clr_err", err, 1'b0);
        expect_rd("st_cleared", 3'd1, 8'h00, 1'b0);

        // Channel 3 RX fill and drain
        for (int unsigned i = 0; i < 16; i++) rx_send(3, 8'(8'hA0 + i));
        check("rxr3_full", dbg_rx_ready, 4'b0111);
        wr_reg(3'd2, 8'd3, err);
        expect_rd("rxcnt_full", 3'd4, 8'd16, 1'b0);
        for (int unsigned i = 0; i < 16; i++) rx_read("rx3_data");
        expect_rd("rx3_empty", 3'd0, 8'h00, 1'b1);
        check("rxr3_back", dbg_rx_ready, 4'hF);

        // RX-available interrupt on channel 0
        wr_reg(3'd2, 8'd0, err);
        wr_reg(3'd3, 8'h01, err);
        expect_rd("ier0", 3'd3, 8'h01, 1'b0);
        rx_send(0, 8'h37);
        check("int_lat0", int_o, 1'b0);
        @(posedge PCLK); #1;
        check("int_set", int_o, 1'b1);
        rx_read("rx0_data");
        check("int_hold", int_o, 1'b1);
        @(posedge PCLK); #1;
        check("int_clr", int_o, 1'b0);
        wr_reg(3'd2, 8'd4, err); check("chsel_bad", err, 1'b1);
        expect_rd("chsel_kept", 3'd2, 8'd0, 1'b0);

`ifdef PERIPHERAL_DBG_JSP_LOOPBACK_EN
        wr_reg(3'd3, 8'h80, err);
        expect_rd("ier_loop", 3'd3, 8'h80, 1'b0);
        check("lb_rxr", dbg_rx_ready[0], 1'b0);
        wr_reg(3'd0, 8'h5A, err); check("lb_wr", err, 1'b0);
        q_rd.push_back(8'h5A);
        check("lb_txv_a", dbg_tx_valid[0], 1'b0);
        @(posedge PCLK); #1;
        check("lb_txv_b", dbg_tx_valid[0], 1'b0);
        expect_rd("lb_rxcnt", 3'd4, 8'd1, 1'b0);
        rx_read("lb_data");
        wr_reg(3'd3, 8'h00, err);
`else
        wr_reg(3'd3, 8'h81, err);
        expect_rd("ier_noloop", 3'd3, 8'h01, 1'b0);
        wr_reg(3'd3, 8'h00, err);
`endif

        // Drain channel 1 in order
        @(negedge PCLK); dbg_tx_ready[1] = 1'b1;
        repeat (16) @(negedge PCLK);
        dbg_tx_ready[1] = 1'b0;
        check("txq_empty", q_tx.size(), 0);
        wr_reg(3'd2, 8'd1, err);
        expect_rd("txcnt1_back", 3'd5, 8'd16, 1'b0);

        // Reset mid-operation discards FIFO contents
        wr_reg(3'd2, 8'd0, err);
        wr_reg(3'd3, 8'h01, err);
        wr_reg(3'd0, 8'hAA, err);
        rx_send(0, 8'h55);
        @(posedge PCLK); #1;
        check("pre_rst_int", int_o, 1'b1);
        check("pre_rst_txv", dbg_tx_valid, 4'b0001);
        @(negedge PCLK); PRESETn = 1'b0;
        #1;
        check("mid_rst_int", int_o, 1'b0);
        check("mid_rst_txv", dbg_tx_valid, 4'h0);
        check("mid_rst_rxr", dbg_rx_ready, 4'hF);
        q_tx.delete();
        q_rd.delete();
        @(negedge PCLK); PRESETn = 1'b1;
        expect_rd("post_rst_st", 3'd1, 8'h02, 1'b0);
        expect_rd("post_rst_rxcnt", 3'd4, 8'd0, 1'b0);
        expect_rd("post_rst_txcnt", 3'd5, 8'd16, 1'b0);
        expect_rd("post_rst_ier", 3'd3, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
